// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazard bubbles, branch flush,
// and a freeze handshake with the multi-cycle data memory.
//
// state | meaning
// IDLE  | no memory access in flight; a MEM-stage access issues sram_start
// BUSY  | waiting for sram_ready or timeout; whole pipeline frozen
// DONE  | one unfrozen cycle so the MEM instruction advances; no re-issue
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter bit FORWARD_EN  = 1'b0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       src1,
   input  logic [4:0]       src2,
   input  logic             two_src,
   input  logic             br_taken,
   input  logic [4:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [4:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_access,
   input  logic             sram_ready,
   output logic             sram_start,
   output logic             pc_freeze,
   output logic             if_id_freeze,
   output logic             id_bubble,
   output logic             back_freeze,
   output logic             if_flush,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] TC_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] tcnt, tcnt_nxt;
   logic       mem_frz;
   logic       start_c;
   logic       err_set;
   logic       m_exe, m_mem;
   logic       haz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         tcnt  <= 8'd0;
      end else begin
         state <= state_nxt;
         tcnt  <= tcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tcnt_nxt  = tcnt;
      mem_frz   = 1'b0;
      start_c   = 1'b0;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            tcnt_nxt = 8'd0;
            if (mem_access) begin
               start_c   = 1'b1;
               mem_frz   = 1'b1;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            mem_frz  = 1'b1;
            tcnt_nxt = tcnt + 8'd1;
            if (sram_ready) begin
               state_nxt = S_DONE;
            end else if (tcnt == TC_LAST) begin
               err_set   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            tcnt_nxt  = 8'd0;
            state_nxt = S_IDLE;
         end
         default: begin
            tcnt_nxt  = 8'd0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Register 0 never carries a dependency.
   always_comb begin
      m_exe = (exe_dest != 5'd0) && ((src1 == exe_dest) || (two_src && (src2 == exe_dest)));
      m_mem = (mem_dest != 5'd0) && ((src1 == mem_dest) || (two_src && (src2 == mem_dest)));
      if (FORWARD_EN) begin
         haz = exe_mem_r_en && m_exe;
      end else begin
         haz = (exe_wb_en && m_exe) || (mem_wb_en && m_mem);
      end
   end

   // Memory freeze outranks hazard stall, which outranks branch flush.
   always_comb begin
      sram_start   = 1'b0;
      pc_freeze    = 1'b0;
      if_id_freeze = 1'b0;
      id_bubble    = 1'b0;
      back_freeze  = 1'b0;
      if_flush     = 1'b0;
      if (!rst) begin
         sram_start = start_c;
         if (mem_frz) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            back_freeze  = 1'b1;
         end else if (haz) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_bubble    = 1'b1;
         end else if (br_taken) begin
            if_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_error   <= 1'b0;
         stall_count <= '0;
      end else begin
         if (err_set) begin
            mem_error <= 1'b1;
         end
         if ((mem_frz || haz) && !(&stall_count)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
- Detects register read-after-write hazards for the instruction in ID and inserts bubbles.
- Applies branch flush to IF.
- Runs a handshake FSM that freezes the whole pipeline while the multi-cycle data memory serves a MEM-stage load/store.
- Keeps a sticky memory-timeout flag and a saturating stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 15: max BUSY cycles waiting for sram_ready before abort; legal 2..255.
- FORWARD_EN, 0: 0 = no forwarding, stall on any EXE/MEM dest match; 1 = forwarding present, stall only on load-use in EXE.
- CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- src1  in  5  ID rs field
- src2  in  5  ID rt field
- two_src  in  1  ID instruction reads src2 (R-type, store, branch)
- br_taken  in  1  ID branch resolved taken
- exe_dest  in  5  destination register in EXE
- exe_wb_en  in  1  EXE instruction writes back
- exe_mem_r_en  in  1  EXE instruction is a load
- mem_dest  in  5  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- mem_access  in  1  MEM instruction is load or store
- sram_ready  in  1  data memory completion, one-cycle pulse
- sram_start  out  1  one-cycle request pulse to data memory
- pc_freeze  out  1  hold PC
- if_id_freeze  out  1  hold IF/ID register
- id_bubble  out  1  load NOP (all enables 0) into ID/EXE
- back_freeze  out  1  hold ID/EXE, EXE/MEM, MEM/WB registers
- if_flush  out  1  replace fetched instruction with NOP
- mem_error  out  1  sticky timeout flag
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, any state): FSM to IDLE, timeout counter 0, mem_error 0, stall_count 0. While rst is high, all control outputs are 0.
- Memory FSM, states IDLE, BUSY, DONE:
  - IDLE with mem_access=1: sram_start=1, mem_frz=1, next BUSY.
  - IDLE with mem_access=0: stays IDLE, mem_frz=0.
  - BUSY: mem_frz=1, tcnt increments each cycle.
    - sram_ready=1: next DONE.
    - Else tcnt==MEM_TIMEOUT-1: set mem_error, next DONE.
  - DONE: mem_frz=0 for exactly one cycle, so the MEM instruction advances. mem_access is ignored in DONE (no re-issue). Next state IDLE, tcnt cleared.
  - sram_ready outside BUSY is ignored.
  - Minimum access cost: ready in the first BUSY cycle gives 2 frozen cycles, then DONE.
  - Back-to-back memory instructions: DONE, then IDLE issues the next start. Gap between sram_start pulses is at least 3 cycles.
- Hazard detect (combinational):
  - m(d) is defined as d!=0 && (src1==d || (two_src && src2==d)).
  - FORWARD_EN=0: haz = (exe_wb_en && m(exe_dest)) || (mem_wb_en && m(mem_dest)).
  - FORWARD_EN=1: haz = exe_mem_r_en && m(exe_dest).
- Output priority:
  1. mem_frz=1: pc_freeze = if_id_freeze = back_freeze = 1; id_bubble=0; if_flush=0.
  2. Else haz=1: pc_freeze=1, if_id_freeze=1, id_bubble=1, back_freeze=0, if_flush=0. A taken branch is held in ID until operands are ready.
  3. Else br_taken=1: if_flush=1, all freezes 0.
  4. Else all outputs 0.
- stall_count: increments on each rising edge where mem_frz or haz is 1 (outside reset). Saturates at all-ones.
- mem_error: cleared only by rst.
- Reset mid-BUSY: pulse abandoned; the first post-reset cycle is IDLE with no start unless mem_access=1.

Test Plan:
1. Load r3 in EXE (exe_mem_r_en=1, exe_wb_en=1, exe_dest=3), ID src1=3, FORWARD_EN=1 -> pc_freeze=1, if_id_freeze=1, id_bubble=1 for 1 cycle; stall_count 0->1.
2. FORWARD_EN=0, mem_wb_en=1, mem_dest=5, src2=5, two_src=0 -> no stall. Then two_src=1 -> stall. Then dest=0, src1=0 -> no stall.
3. mem_access=1, sram_ready 3 cycles after start -> sram_start pulse on cycle 0; back_freeze=1 on cycles 0..3; DONE on cycle 4 with freezes 0; mem_error=0.
4. mem_access=1, sram_ready never, MEM_TIMEOUT=15 -> freeze held on cycles 0..15; mem_error=1 from cycle 16 and stays 1; DONE on cycle 16.
5. br_taken=1 with haz=1, then haz drops -> if_flush=0 while stalled, if_flush=1 on the first non-stalled cycle. br_taken=1 during mem_frz -> if_flush=0.
6. Assert rst during BUSY -> all outputs 0 immediately; after release, state IDLE, stall_count=0, mem_error=0; late sram_ready ignored.
